// File: rtl/xbar_rr_nxm.sv
// NM-master x NS-slave req/ack crossbar: slave chosen by top address bits, per-slave round-robin arbitration.
// Latency: s_req one cycle after the grant edge; m_ack/m_rdata one cycle after the s_ack edge.
// Backpressure: a busy slave channel holds its request until s_ack; losing masters keep m_req high and wait.
module xbar_rr_nxm #(
    parameter int NM = 2,
    parameter int NS = 2,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NM-1:0]    m_req,
    input  logic [NM*AW-1:0] m_addr,
    input  logic [NM-1:0]    m_cmd,
    input  logic [NM*DW-1:0] m_wdata,
    output logic [NM-1:0]    m_ack,
    output logic [NM*DW-1:0] m_rdata,
    output logic [NS-1:0]    s_req,
    output logic [NS*AW-1:0] s_addr,
    output logic [NS-1:0]    s_cmd,
    output logic [NS*DW-1:0] s_wdata,
    input  logic [NS-1:0]    s_ack,
    input  logic [NS*DW-1:0] s_rdata
);

    localparam int SW  = (NS > 1) ? $clog2(NS) : 1;
    localparam int MIW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic {IDLE, BUSY} ch_state_e;

    logic [AW-1:0] m_addr_a  [NM];
    logic [DW-1:0] m_wdata_a [NM];
    logic [SW-1:0] m_slv     [NM];
    logic [DW-1:0] s_rdata_a [NS];

    ch_state_e      state_q   [NS];
    logic [MIW-1:0] owner_q   [NS];
    logic [MIW-1:0] ptr_q     [NS];
    logic [NS-1:0]  s_req_q;
    logic [AW-1:0]  s_addr_q  [NS];
    logic [NS-1:0]  s_cmd_q;
    logic [DW-1:0]  s_wdata_q [NS];
    logic [NM-1:0]  m_ack_q;
    logic [DW-1:0]  m_rdata_q [NM];

    logic [NS-1:0]  gnt_vld;
    logic [MIW-1:0] gnt_idx   [NS];
    logic [NM-1:0]  m_ack_d;
    logic [DW-1:0]  m_rdata_d [NM];

    for (genvar i = 0; i < NM; i++) begin : g_m
        assign m_addr_a[i]             = m_addr[i*AW +: AW];
        assign m_wdata_a[i]            = m_wdata[i*DW +: DW];
        assign m_slv[i]                = m_addr[i*AW + AW-1 -: SW];
        assign m_rdata[i*DW +: DW]     = m_rdata_q[i];
    end

    for (genvar s = 0; s < NS; s++) begin : g_s
        assign s_rdata_a[s]            = s_rdata[s*DW +: DW];
        assign s_addr[s*AW +: AW]      = s_addr_q[s];
        assign s_wdata[s*DW +: DW]     = s_wdata_q[s];
    end

    assign m_ack = m_ack_q;
    assign s_req = s_req_q;
    assign s_cmd = s_cmd_q;

    // Scan from the farthest master down to ptr+1 so the nearest candidate after the pointer wins.
    // A master acked this cycle is still holding its old request, so it is masked out.
    always_comb begin
        int             idx;
        logic [MIW-1:0] ci;
        idx = 0;
        ci  = '0;
        for (int s = 0; s < NS; s++) begin
            gnt_vld[s] = 1'b0;
            gnt_idx[s] = '0;
            for (int k = NM; k >= 1; k--) begin
                idx = int'(ptr_q[s]) + k;
                if (idx >= NM) idx = idx - NM;
                ci = MIW'(idx);
                if (m_req[ci] && !m_ack_q[ci] && (m_slv[ci] == SW'(s))) begin
                    gnt_vld[s] = 1'b1;
                    gnt_idx[s] = ci;
                end
            end
        end
    end

    // A master owns at most one channel, so acks from different slaves never collide.
    always_comb begin
        m_ack_d = '0;
        for (int i = 0; i < NM; i++) m_rdata_d[i] = m_rdata_q[i];
        for (int s = 0; s < NS; s++) begin
            if (state_q[s] == BUSY && s_ack[s]) begin
                m_ack_d[owner_q[s]]   = 1'b1;
                m_rdata_d[owner_q[s]] = s_rdata_a[s];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ack_q <= '0;
            s_req_q <= '0;
            s_cmd_q <= '0;
            for (int i = 0; i < NM; i++) m_rdata_q[i] <= '0;
            for (int s = 0; s < NS; s++) begin
                state_q[s]   <= IDLE;
                owner_q[s]   <= '0;
                ptr_q[s]     <= MIW'(NM-1);
                s_addr_q[s]  <= '0;
                s_wdata_q[s] <= '0;
            end
        end else begin
            m_ack_q <= m_ack_d;
            for (int i = 0; i < NM; i++) m_rdata_q[i] <= m_rdata_d[i];
            for (int s = 0; s < NS; s++) begin
                case (state_q[s])
                    IDLE: begin
                        if (gnt_vld[s]) begin
                            state_q[s]   <= BUSY;
                            owner_q[s]   <= gnt_idx[s];
                            ptr_q[s]     <= gnt_idx[s];
                            s_req_q[s]   <= 1'b1;
                            s_addr_q[s]  <= m_addr_a[gnt_idx[s]];
                            s_cmd_q[s]   <= m_cmd[gnt_idx[s]];
                            s_wdata_q[s] <= m_wdata_a[gnt_idx[s]];
                        end
                    end
                    BUSY: begin
                        if (s_ack[s]) begin
                            state_q[s] <= IDLE;
                            s_req_q[s] <= 1'b0;
                        end
                    end
                    default: state_q[s] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xbar_rr_nxm.sv
// Directed bench for xbar_rr_nxm: a 2x2 instance for routing/arbitration/reset and a 4x4 instance for RR fairness.
module tb_xbar_rr_nxm;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   m_req, m_cmd, m_ack, s_req, s_cmd, s_ack;
    logic [63:0]  m_addr, m_wdata, m_rdata, s_addr, s_wdata, s_rdata;

    logic [3:0]   m4_req, m4_cmd, m4_ack, s4_req, s4_cmd, s4_ack;
    logic [127:0] m4_addr, m4_wdata, m4_rdata, s4_addr, s4_wdata, s4_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Zero-wait slave 2 on the 4x4 instance: acks in every cycle its request is up.
    assign s4_ack   = s4_req & 4'b0100;
    assign s4_rdata = '0;

    xbar_rr_nxm #(.NM(2), .NS(2), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata),
        .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata)
    );

    xbar_rr_nxm #(.NM(4), .NS(4), .AW(32), .DW(32)) dut4 (
        .clk(clk), .reset(reset),
        .m_req(m4_req), .m_addr(m4_addr), .m_cmd(m4_cmd), .m_wdata(m4_wdata),
        .m_ack(m4_ack), .m_rdata(m4_rdata),
        .s_req(s4_req), .s_addr(s4_addr), .s_cmd(s4_cmd), .s_wdata(s4_wdata),
        .s_ack(s4_ack), .s_rdata(s4_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        int n, cyc, idx;
        int cnt [4];

        reset = 1'b1;
        m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0; s_ack = '0; s_rdata = '0;
        m4_req = '0; m4_cmd = '0; m4_addr = '0; m4_wdata = '0;
        repeat (2) tick();
        chk("rst_s_req", {62'd0, s_req}, 0);
        chk("rst_m_ack", {62'd0, m_ack}, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_m_rdata", m_rdata, 0);
        reset = 1'b0;
        tick();

        // 1: single read, slave0 answers after two wait cycles
        m_req = 2'b01; m_addr[31:0] = 32'h0000_0010; m_cmd = 2'b00;
        tick();
        chk("t1_s_req", {62'd0, s_req}, 2'b01);
        chk("t1_s_addr0", {32'd0, s_addr[31:0]}, 32'h0000_0010);
        repeat (2) begin
            tick();
            chk("t1_wait_s_req", {62'd0, s_req}, 2'b01);
            chk("t1_wait_m_ack", {62'd0, m_ack}, 0);
        end
        s_ack = 2'b01; s_rdata[31:0] = 32'hDEAD_BEEF;
        tick();
        s_ack = '0; m_req = '0;
        chk("t1_m_ack", {62'd0, m_ack}, 2'b01);
        chk("t1_m_rdata0", {32'd0, m_rdata[31:0]}, 32'hDEAD_BEEF);
        chk("t1_s_req_drop", {62'd0, s_req}, 0);
        tick();
        chk("t1_ack_pulse", {62'd0, m_ack}, 0);
        chk("t1_rdata_hold", {32'd0, m_rdata[31:0]}, 32'hDEAD_BEEF);

        // 2: contention on slave1, requests held continuously, zero-wait slave
        m_req = 2'b11; m_cmd = 2'b00;
        m_addr[31:0] = 32'h8000_0000; m_addr[63:32] = 32'h8000_0004;
        tick();
        chk("t2_g1_s_req", {62'd0, s_req}, 2'b10);
        chk("t2_g1_owner_m0", {32'd0, s_addr[63:32]}, 32'h8000_0000);
        s_ack = 2'b10; s_rdata[63:32] = 32'hA0A0_0000;
        tick();
        s_ack = '0;
        chk("t2_ack_m0", {62'd0, m_ack}, 2'b01);
        chk("t2_rdata_m0", {32'd0, m_rdata[31:0]}, 32'hA0A0_0000);
        tick();
        chk("t2_g2_s_req", {62'd0, s_req}, 2'b10);
        chk("t2_g2_owner_m1", {32'd0, s_addr[63:32]}, 32'h8000_0004);
        chk("t2_g2_no_ack", {62'd0, m_ack}, 0);
        s_ack = 2'b10; s_rdata[63:32] = 32'hA1A1_0001;
        tick();
        s_ack = '0;
        chk("t2_ack_m1", {62'd0, m_ack}, 2'b10);
        chk("t2_rdata_m1", {32'd0, m_rdata[63:32]}, 32'hA1A1_0001);
        tick();
        chk("t2_g3_owner_m0", {32'd0, s_addr[63:32]}, 32'h8000_0000);
        s_ack = 2'b10; s_rdata[63:32] = 32'hA2A2_0002;
        tick();
        s_ack = '0; m_req = '0;
        chk("t2_ack3_m0", {62'd0, m_ack}, 2'b01);
        chk("t2_rdata3_m0", {32'd0, m_rdata[31:0]}, 32'hA2A2_0002);
        tick();
        chk("t2_idle", {62'd0, s_req}, 0);

        // 3: parallel write to slave0 and read from slave1
        m_req = 2'b11; m_cmd = 2'b01;
        m_addr[31:0] = 32'h0000_0020; m_wdata[31:0] = 32'h1234_5678;
        m_addr[63:32] = 32'h8000_0040;
        tick();
        chk("t3_both_granted", {62'd0, s_req}, 2'b11);
        chk("t3_s_wdata0", {32'd0, s_wdata[31:0]}, 32'h1234_5678);
        chk("t3_s_cmd", {62'd0, s_cmd}, 2'b01);
        chk("t3_s_addr1", {32'd0, s_addr[63:32]}, 32'h8000_0040);
        s_ack = 2'b01; s_rdata[31:0] = 32'h5555_0000;
        tick();
        s_ack = '0; m_req[0] = 1'b0;
        chk("t3_ack_m0", {62'd0, m_ack}, 2'b01);
        chk("t3_wr_rdata_capt", {32'd0, m_rdata[31:0]}, 32'h5555_0000);
        chk("t3_s1_still_busy", {62'd0, s_req}, 2'b10);
        chk("t3_s_addr0_hold", {32'd0, s_addr[31:0]}, 32'h0000_0020);
        s_ack = 2'b10; s_rdata[63:32] = 32'hCAFE_F00D;
        tick();
        s_ack = '0; m_req = '0;
        chk("t3_ack_m1", {62'd0, m_ack}, 2'b10);
        chk("t3_rdata_m1", {32'd0, m_rdata[63:32]}, 32'hCAFE_F00D);
        chk("t3_rdata_m0_kept", {32'd0, m_rdata[31:0]}, 32'h5555_0000);
        tick();

        // 4: four masters hammer slave2 of the 4x4 instance
        for (int j = 0; j < 4; j++) begin
            m4_addr[j*32 +: 32] = 32'h8000_0000;
            cnt[j] = 0;
        end
        m4_req = 4'hF;
        n = 0; cyc = 0;
        while (n < 12 && cyc < 80) begin
            tick();
            cyc++;
            if (m4_ack != 0) begin
                chk("t4_onehot", {63'd0, $onehot(m4_ack)}, 1);
                idx = 0;
                for (int j = 0; j < 4; j++) if (m4_ack[j]) idx = j;
                cnt[idx]++;
                chk("t4_order", idx, n % 4);
                n++;
                if (n == 12) m4_req = '0;
            end
        end
        m4_req = '0;
        chk("t4_total", n, 12);
        for (int j = 0; j < 4; j++) chk("t4_per_master", cnt[j], 3);
        tick();

        // 5: spurious ack on an idle channel
        s_ack = 2'b10; s_rdata[63:32] = 32'hBADB_AD00;
        tick();
        s_ack = '0;
        chk("t5_no_ack", {62'd0, m_ack}, 0);
        tick();
        chk("t5_no_ack_late", {62'd0, m_ack}, 0);
        chk("t5_rdata1_kept", {32'd0, m_rdata[63:32]}, 32'hCAFE_F00D);

        // 6: reset while slave0 busy, then m1 gets the channel
        m_req = 2'b01; m_cmd = 2'b00; m_addr[31:0] = 32'h0000_0030;
        tick();
        chk("t6_busy", {62'd0, s_req}, 2'b01);
        reset = 1'b1;
        #1;
        chk("t6_rst_s_req", {62'd0, s_req}, 0);
        chk("t6_rst_m_ack", {62'd0, m_ack}, 0);
        chk("t6_rst_m_rdata", m_rdata, 0);
        m_req = 2'b10; m_addr[63:32] = 32'h0000_0050;
        tick();
        reset = 1'b0;
        chk("t6_no_abort_ack", {62'd0, m_ack}, 0);
        tick();
        chk("t6_m1_granted", {62'd0, s_req}, 2'b01);
        chk("t6_s_addr0_m1", {32'd0, s_addr[31:0]}, 32'h0000_0050);
        s_ack = 2'b01; s_rdata[31:0] = 32'h0BAD_F00D;
        tick();
        s_ack = '0; m_req = '0;
        chk("t6_ack_m1", {62'd0, m_ack}, 2'b10);
        chk("t6_rdata_m1", {32'd0, m_rdata[63:32]}, 32'h0BAD_F00D);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
